square_motion: RTL and testbench
================================

SQUARE_MOTION -- requirements
Module: square_motion

Interface
REQ-001 The block SHALL have one clock, clk_pix; reset rst_pix is synchronous and active-high.
REQ-002 Parameters (name, default, meaning), one per line:
- SIZE, 50: square edge in pixels.
- SPEED, 2: pixels moved per axis per update.
- H_RES, 640: active width.
- V_RES, 480: active height.
- START_X, 100: reset x.
- START_Y, 100: reset y.
- START_DIR, 2'b00: reset {dir_y,dir_x}; 0 means increasing.
- FRAME_DIV, 1: update on every FRAME_DIV-th frame tick, range 1..255.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk_pix, in, 1: pixel clock.
- rst_pix, in, 1: synchronous active-high reset.
- sx, in, 10: current scan x from the timing generator.
- sy, in, 10: current scan y.
- enable, in, 1: motion enable.
- osq_x, in, 10: other square top-left x.
- osq_y, in, 10: other square top-left y.
- pos_x, out, 10: square top-left x, to the painter.
- pos_y, out, 10: square top-left y.
- dir_x, out, 1: x direction, 1 means decreasing.
- dir_y, out, 1: y direction, 1 means decreasing.
- busy, out, 1: FSM not IDLE.
- hit_wall, out, 1: one-cycle pulse on a wall bounce.
- hit_square, out, 1: one-cycle pulse on a square collision.

Function
REQ-004 A frame tick SHALL occur on any edge where sx==0, sy==V_RES and enable==1, with the FSM in IDLE; ticks at other times SHALL be ignored.
REQ-005 An 8-bit divider SHALL count ticks; the FSM starts only on the tick where the count reaches FRAME_DIV-1, after which the count SHALL wrap to 0.
REQ-006 FSM states SHALL be IDLE, STEP_X, STEP_Y, COLLIDE, COMMIT, advancing in that order with one state per cycle, then COMMIT->IDLE.
REQ-007 STEP_X SHALL compute candidate x using 11-bit arithmetic:
- Increasing: if pos_x+SPEED+SIZE>=H_RES, clamp to H_RES-SIZE and flip dir_x.
- Decreasing: if pos_x<SPEED, clamp to 0 and flip dir_x.
- Otherwise candidate x = pos_x±SPEED.
REQ-008 STEP_Y SHALL apply the same rule as REQ-007 with V_RES and dir_y.
REQ-009 COLLIDE SHALL test AABB overlap of the candidate square against the other square: cx<osq_x+SIZE && osq_x<cx+SIZE && cy<osq_y+SIZE && osq_y<cy+SIZE, all 11-bit.
- On overlap, the candidate SHALL be discarded (position unchanged), both dir bits SHALL be inverted relative to their pre-update values, and a square hit SHALL be flagged.
REQ-010 COMMIT SHALL load pos_x/pos_y and dir_x/dir_y.
- hit_wall SHALL pulse for exactly one cycle if any clamp occurred and no square hit was flagged.
- hit_square SHALL pulse for exactly one cycle if a square hit was flagged.
REQ-011 Latency SHALL be: tick sampled on edge E, and new pos/dir/hit visible after edge E+4.
- busy SHALL be high after edges E..E+3 and low after E+4.
REQ-012 pos_x/pos_y SHALL change only on the COMMIT edge, which always falls inside vertical blank.
REQ-013 If enable is deasserted mid-update, the update SHALL complete; subsequent ticks are ignored.

Reset
REQ-014 On rst_pix the block SHALL set:
- pos_x=START_X, pos_y=START_Y.
- {dir_y,dir_x}=START_DIR.
- busy=0, hit_wall=0, hit_square=0.
- state=IDLE, divider=0.
- Any in-flight candidate SHALL be discarded.
REQ-015 Reset asserted in any state SHALL take effect on the next edge, with no hit pulse emitted.

Configuration
REQ-016 Macro SQUARE_MOTION_COLLIDE_EN, defined:
- COLLIDE state and REQ-009 are present.
- Latency is 4 edges.
REQ-017 Macro SQUARE_MOTION_COLLIDE_EN, undefined:
- COLLIDE state is removed, so STEP_Y goes directly to COMMIT.
- Latency is 3 edges, and busy is high for 3 cycles.
- osq_x/osq_y are ignored.
- hit_square is tied to 0.

Verification
REQ-018 Defaults, reset, one tick, osq far (500,0): pos goes (100,100)->(102,102) 4 edges after the tick; busy high 4 cycles; no hit pulses.
REQ-019 START_X=589, one tick: pos_x=590, dir_x=1, hit_wall 1-cycle pulse; next tick gives pos_x=588.
REQ-020 START_X=1, START_DIR=2'b01, one tick: pos_x=0, dir_x=0, hit_wall pulse; next tick gives pos_x=2.
REQ-021 Square collision, osq=(150,100), START=(100,100), one tick:
- Macro defined: pos stays (100,100), dir={1,1}, hit_square pulse, hit_wall=0.
- Macro undefined: pos=(102,102), no hit pulse.
REQ-022 Gating and divider: enable=0 for 3 ticks gives pos unchanged and busy never high; then enable=1 with FRAME_DIV=2 gives exactly one update per 2 ticks.
REQ-023 rst_pix asserted while in STEP_Y: next edge gives pos=(START_X,START_Y), busy=0, hit_wall=hit_square=0, and no COMMIT occurs.

Source files
------------

// File: rtl/square_motion.sv
// -----------------------------------------------------------------------------
// square_motion
//   Moves one square around the active area once per (divided) frame. The
//   update runs during vertical blank as a short state sequence: step x, step
//   y, optionally test against a second square, then commit. The square
//   bounces off the screen edges and, with collision enabled, off the other
//   square.
//
// Build option:
//   SQUARE_MOTION_COLLIDE_EN  defined   -> COLLIDE state present, 4-edge update
//                             undefined -> no collision test, 3-edge update,
//                                          osq_x/osq_y ignored, hit_square = 0
//
// Ports:
//   clk_pix     pixel clock
//   rst_pix     synchronous active-high reset
//   sx, sy      current scan position from the timing generator
//   enable      motion enable (only gates the start of an update)
//   osq_x/y     top-left corner of the other square
//   pos_x/y     top-left corner of this square
//   dir_x/y     travel direction, 1 = decreasing
//   busy        an update is in flight
//   hit_wall    one-cycle pulse when the committed update clamped at an edge
//   hit_square  one-cycle pulse when the update was rejected by a collision
// -----------------------------------------------------------------------------
module square_motion #(
  parameter int unsigned SIZE      = 50,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned START_X   = 100,
  parameter int unsigned START_Y   = 100,
  parameter logic [1:0]  START_DIR = 2'b00,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       enable,
  input  logic [9:0] osq_x,
  input  logic [9:0] osq_y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       busy,
  output logic       hit_wall,
  output logic       hit_square
);

  // Position arithmetic is done one bit wider so pos+SPEED+SIZE cannot wrap.
  localparam int unsigned CW       = 11;
  localparam int unsigned PW       = 10;
  localparam int unsigned DW       = 8;
  localparam logic [CW-1:0] SIZE_W  = CW'(SIZE);
  localparam logic [CW-1:0] SPEED_W = CW'(SPEED);
  localparam logic [CW-1:0] H_W     = CW'(H_RES);
  localparam logic [CW-1:0] V_W     = CW'(V_RES);
  localparam logic [PW-1:0] V_TICK  = PW'(V_RES);
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

`ifdef SQUARE_MOTION_COLLIDE_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP_X  = 3'd1,
    STEP_Y  = 3'd2,
    COLLIDE = 3'd3,
    COMMIT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP_X  = 3'd1,
    STEP_Y  = 3'd2,
    COMMIT  = 3'd4
  } state_t;
`endif

  // Result of stepping one axis: new position, new direction, clamp flag.
  typedef struct packed {
    logic          clamp;
    logic          dir;
    logic [PW-1:0] pos;
  } axis_t;

  // One axis step with edge clamping; limit is the active extent of the axis.
  function automatic axis_t step_axis(input logic [PW-1:0] pos,
                                      input logic          dir,
                                      input logic [CW-1:0] limit);
    axis_t         r;
    logic [CW-1:0] p;
    p       = {1'b0, pos};
    r.clamp = 1'b0;
    r.dir   = dir;
    r.pos   = pos;
    if (!dir) begin
      if (p + SPEED_W + SIZE_W >= limit) begin
        r.pos   = PW'(limit - SIZE_W);
        r.dir   = 1'b1;
        r.clamp = 1'b1;
      end else begin
        r.pos = PW'(p + SPEED_W);
      end
    end else begin
      if (p < SPEED_W) begin
        r.pos   = '0;
        r.dir   = 1'b0;
        r.clamp = 1'b1;
      end else begin
        r.pos = PW'(p - SPEED_W);
      end
    end
    return r;
  endfunction

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] cand_x;
  logic [PW-1:0] cand_y;
  logic          cand_dx;
  logic          cand_dy;
  logic          clamp_any;

  axis_t step_x_c;
  axis_t step_y_c;
  logic  tick_c;

  // Frame tick: first pixel of the first blanking line, while enabled.
  assign tick_c = (sx == '0) && (sy == V_TICK) && enable;

  // Candidate moves are always derived from the committed position/direction.
  always_comb begin
    step_x_c = step_axis(pos_x, dir_x, H_W);
    step_y_c = step_axis(pos_y, dir_y, V_W);
  end

`ifdef SQUARE_MOTION_COLLIDE_EN
  logic          sq_hit;
  logic          overlap_c;
  logic [CW-1:0] cx_w;
  logic [CW-1:0] cy_w;
  logic [CW-1:0] ox_w;
  logic [CW-1:0] oy_w;

  // Axis-aligned overlap of the candidate square with the other square.
  always_comb begin
    cx_w      = {1'b0, cand_x};
    cy_w      = {1'b0, cand_y};
    ox_w      = {1'b0, osq_x};
    oy_w      = {1'b0, osq_y};
    overlap_c = (cx_w < ox_w + SIZE_W) && (ox_w < cx_w + SIZE_W) &&
                (cy_w < oy_w + SIZE_W) && (oy_w < cy_w + SIZE_W);
  end
`else
  logic unused_osq;
  assign unused_osq = ^{osq_x, osq_y};
  assign hit_square = 1'b0;
`endif

  // Update sequencer; all outputs are registered here.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state     <= IDLE;
      div_cnt   <= '0;
      pos_x     <= PW'(START_X);
      pos_y     <= PW'(START_Y);
      dir_x     <= START_DIR[0];
      dir_y     <= START_DIR[1];
      busy      <= 1'b0;
      hit_wall  <= 1'b0;
      cand_x    <= '0;
      cand_y    <= '0;
      cand_dx   <= 1'b0;
      cand_dy   <= 1'b0;
      clamp_any <= 1'b0;
`ifdef SQUARE_MOTION_COLLIDE_EN
      sq_hit     <= 1'b0;
      hit_square <= 1'b0;
`endif
    end else begin
      // Hit flags are single-cycle pulses raised only in COMMIT.
      hit_wall <= 1'b0;
`ifdef SQUARE_MOTION_COLLIDE_EN
      hit_square <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // Divider only advances on accepted ticks.
          if (tick_c) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              state   <= STEP_X;
              busy    <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
        end

        STEP_X: begin
          cand_x    <= step_x_c.pos;
          cand_dx   <= step_x_c.dir;
          clamp_any <= step_x_c.clamp;
`ifdef SQUARE_MOTION_COLLIDE_EN
          sq_hit    <= 1'b0;
`endif
          state     <= STEP_Y;
        end

        STEP_Y: begin
          cand_y    <= step_y_c.pos;
          cand_dy   <= step_y_c.dir;
          clamp_any <= clamp_any | step_y_c.clamp;
`ifdef SQUARE_MOTION_COLLIDE_EN
          state     <= COLLIDE;
`else
          state     <= COMMIT;
`endif
        end

`ifdef SQUARE_MOTION_COLLIDE_EN
        COLLIDE: begin
          // On overlap keep the old position and reverse both pre-update dirs.
          if (overlap_c) begin
            cand_x  <= pos_x;
            cand_y  <= pos_y;
            cand_dx <= ~dir_x;
            cand_dy <= ~dir_y;
            sq_hit  <= 1'b1;
          end
          state <= COMMIT;
        end
`endif

        COMMIT: begin
          pos_x <= cand_x;
          pos_y <= cand_y;
          dir_x <= cand_dx;
          dir_y <= cand_dy;
`ifdef SQUARE_MOTION_COLLIDE_EN
          hit_wall   <= clamp_any & ~sq_hit;
          hit_square <= sq_hit;
`else
          hit_wall   <= clamp_any;
`endif
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_motion.sv
// -----------------------------------------------------------------------------
// tb_square_motion
//   Four square_motion instances share one stimulus stream: defaults, a square
//   starting near the right edge, one near the left edge moving left, and one
//   with a frame divider of 2. Directed scenarios plus a randomized run are
//   checked against an update-level model of each square.
// -----------------------------------------------------------------------------
module tb_square_motion;

  localparam int N     = 4;
  localparam int SIZE  = 50;
  localparam int SPEED = 2;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
`ifdef SQUARE_MOTION_COLLIDE_EN
  localparam int LAT = 4;
  localparam bit CEN = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit CEN = 1'b0;
`endif
  localparam int ST_X [N] = '{100, 589, 1, 100};
  localparam int ST_D [N] = '{0, 0, 1, 0};
  localparam int FDIV [N] = '{1, 1, 1, 2};

  typedef struct {
    int x;
    int y;
    bit dx;
    bit dy;
    int cnt;
  } msq_t;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic [9:0] sx, sy, osq_x, osq_y;
  logic       enable;
  logic [9:0] pos_x [N];
  logic [9:0] pos_y [N];
  logic       dir_x [N];
  logic       dir_y [N];
  logic       busy [N];
  logic       hit_wall [N];
  logic       hit_square [N];

  msq_t m [N];
  int   total = 0;
  int   bad   = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    square_motion #(
      .START_X  (ST_X[g]),
      .START_DIR(2'(ST_D[g])),
      .FRAME_DIV(FDIV[g])
    ) u_dut (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .sx        (sx),
      .sy        (sy),
      .enable    (enable),
      .osq_x     (osq_x),
      .osq_y     (osq_y),
      .pos_x     (pos_x[g]),
      .pos_y     (pos_y[g]),
      .dir_x     (dir_x[g]),
      .dir_y     (dir_y[g]),
      .busy      (busy[g]),
      .hit_wall  (hit_wall[g]),
      .hit_square(hit_square[g])
    );
  end

  always #5 clk_pix = ~clk_pix;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model (one call = one accepted frame tick) ----
  function automatic void model_init();
    for (int i = 0; i < N; i++) begin
      int d;
      d        = ST_D[i];
      m[i].x   = ST_X[i];
      m[i].y   = 100;
      m[i].dx  = d[0];
      m[i].dy  = d[1];
      m[i].cnt = 0;
    end
  endfunction

  function automatic void axis(input int p, input bit d, input int res,
                               output int np, output bit nd, output bit cl);
    cl = 1'b0;
    nd = d;
    if (!d) begin
      if (p + SPEED + SIZE >= res) begin np = res - SIZE; nd = 1'b1; cl = 1'b1; end
      else np = p + SPEED;
    end else begin
      if (p < SPEED) begin np = 0; nd = 1'b0; cl = 1'b1; end
      else np = p - SPEED;
    end
  endfunction

  function automatic void model_tick(input int i, input int ox, input int oy,
                                     output bit upd, output bit hw, output bit hs);
    int nx, ny;
    bit ndx, ndy, cx, cy;
    upd = 1'b0; hw = 1'b0; hs = 1'b0;
    m[i].cnt++;
    if (m[i].cnt < FDIV[i]) return;
    m[i].cnt = 0;
    upd = 1'b1;
    axis(m[i].x, m[i].dx, H_RES, nx, ndx, cx);
    axis(m[i].y, m[i].dy, V_RES, ny, ndy, cy);
    if (CEN && nx < ox + SIZE && ox < nx + SIZE && ny < oy + SIZE && oy < ny + SIZE) begin
      m[i].dx = !m[i].dx;
      m[i].dy = !m[i].dy;
      hs = 1'b1;
    end else begin
      m[i].x  = nx;
      m[i].y  = ny;
      m[i].dx = ndx;
      m[i].dy = ndy;
      hw = cx | cy;
    end
  endfunction

  function automatic logic [24:0] obs(input int i);
    return {pos_x[i], pos_y[i], dir_x[i], dir_y[i], busy[i], hit_wall[i], hit_square[i]};
  endfunction

  function automatic logic [24:0] expv(input msq_t s, input bit b, input bit hw, input bit hs);
    return {10'(s.x), 10'(s.y), s.dx, s.dy, b, hw, hs};
  endfunction

  function automatic string fmt(input logic [24:0] v);
    return $sformatf("pos=(%0d,%0d) dir_x=%b dir_y=%b busy=%b hit_wall=%b hit_square=%b",
                     v[24:15], v[14:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic drive_idle();
    sx = 10'd5;
    sy = 10'd0;
  endtask

  task automatic drive_tick();
    sx = 10'd0;
    sy = 10'(V_RES);
  endtask

  task automatic apply_reset();
    rst_pix = 1'b1;
    drive_idle();
    step();
    step();
    rst_pix = 1'b0;
    model_init();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_pix = 1'b1; enable = 1'b1; osq_x = 10'd500; osq_y = 10'd0;
    drive_tick();
    step();
    step();
    model_init();
    for (int i = 0; i < N; i++) begin
      total++;
      if (obs(i) !== expv(m[i], 1'b0, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_state inst=%0d got %s want %s", i, fmt(obs(i)), fmt(expv(m[i], 1'b0, 1'b0, 1'b0)));
      end
    end
    rst_pix = 1'b0;
    drive_idle();
    step();
    for (int i = 0; i < N; i++) begin
      total++;
      if (obs(i) !== expv(m[i], 1'b0, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_release inst=%0d got %s want %s", i, fmt(obs(i)), fmt(expv(m[i], 1'b0, 1'b0, 1'b0)));
      end
    end
  endtask

  task automatic test_single_update();
    apply_reset();
    osq_x = 10'd500; osq_y = 10'd0; enable = 1'b1;
    drive_tick();
    step();
    drive_idle();
    for (int k = 0; k <= LAT + 1; k++) begin
      int e;
      e = (k < LAT) ? 100 : 102;
      total++;
      if (busy[0] !== 1'(k < LAT)) begin
        bad++;
        $display("FAIL single_busy edge=E+%0d got %b want %b", k, busy[0], 1'(k < LAT));
      end
      total++;
      if ({pos_x[0], pos_y[0], hit_wall[0], hit_square[0]} !== {10'(e), 10'(e), 2'b00}) begin
        bad++;
        $display("FAIL single_pos edge=E+%0d got (%0d,%0d) hw=%b hs=%b want (%0d,%0d) hw=0 hs=0",
                 k, pos_x[0], pos_y[0], hit_wall[0], hit_square[0], e, e);
      end
      if (k <= LAT) step();
    end
  endtask

  task automatic test_wall_bounce();
    apply_reset();
    osq_x = 10'd500; osq_y = 10'd0; enable = 1'b1;
    drive_tick();
    step();
    drive_idle();
    repeat (LAT - 1) step();
    total++;
    if (hit_wall[1] !== 1'b0 || pos_x[1] !== 10'd589) begin
      bad++;
      $display("FAIL wall_early got pos_x=%0d hw=%b want 589 hw=0", pos_x[1], hit_wall[1]);
    end
    step();
    total++;
    if ({pos_x[1], dir_x[1], hit_wall[1], hit_square[1]} !== {10'd590, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wall_right got pos_x=%0d dir_x=%b hw=%b hs=%b want 590 1 1 0",
               pos_x[1], dir_x[1], hit_wall[1], hit_square[1]);
    end
    total++;
    if ({pos_x[2], dir_x[2], hit_wall[2], hit_square[2]} !== {10'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wall_left got pos_x=%0d dir_x=%b hw=%b hs=%b want 0 0 1 0",
               pos_x[2], dir_x[2], hit_wall[2], hit_square[2]);
    end
    step();
    total++;
    if (hit_wall[1] !== 1'b0 || hit_wall[2] !== 1'b0) begin
      bad++;
      $display("FAIL wall_pulse_width got hw_right=%b hw_left=%b want 0 0", hit_wall[1], hit_wall[2]);
    end
    step();
    drive_tick();
    step();
    drive_idle();
    repeat (LAT) step();
    total++;
    if ({pos_x[1], dir_x[1], hit_wall[1]} !== {10'd588, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL wall_right_next got pos_x=%0d dir_x=%b hw=%b want 588 1 0", pos_x[1], dir_x[1], hit_wall[1]);
    end
    total++;
    if ({pos_x[2], dir_x[2], hit_wall[2]} !== {10'd2, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL wall_left_next got pos_x=%0d dir_x=%b hw=%b want 2 0 0", pos_x[2], dir_x[2], hit_wall[2]);
    end
  endtask

  task automatic test_collision();
    int  ep;
    logic ed, ehs;
    ep  = CEN ? 100 : 102;
    ed  = CEN;
    ehs = CEN;
    apply_reset();
    osq_x = 10'd150; osq_y = 10'd100; enable = 1'b1;
    drive_tick();
    step();
    drive_idle();
    repeat (LAT) step();
    total++;
    if ({pos_x[0], pos_y[0], dir_x[0], dir_y[0], busy[0], hit_wall[0], hit_square[0]} !==
        {10'(ep), 10'(ep), ed, ed, 1'b0, 1'b0, ehs}) begin
      bad++;
      $display("FAIL collide got %s want pos=(%0d,%0d) dir=%b%b busy=0 hw=0 hs=%b",
               fmt(obs(0)), ep, ep, ed, ed, ehs);
    end
    step();
    total++;
    if (hit_square[0] !== 1'b0 || hit_wall[0] !== 1'b0) begin
      bad++;
      $display("FAIL collide_pulse_width got hs=%b hw=%b want 0 0", hit_square[0], hit_wall[0]);
    end
  endtask

  task automatic test_gating_divider();
    apply_reset();
    osq_x = 10'd500; osq_y = 10'd0; enable = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive_tick();
      step();
      drive_idle();
      for (int k = 0; k <= LAT + 1; k++) begin
        total++;
        if (busy[0] | busy[1] | busy[2] | busy[3]) begin
          bad++;
          $display("FAIL gate_busy tick=%0d edge=E+%0d got busy=%b%b%b%b want 0000",
                   t, k, busy[0], busy[1], busy[2], busy[3]);
        end
        step();
      end
    end
    // Near-miss scan positions with enable high must not start an update.
    enable = 1'b1;
    sx = 10'd0; sy = 10'(V_RES - 1); step();
    sx = 10'd1; sy = 10'(V_RES);     step();
    drive_idle();
    step();
    total++;
    if (busy[0] | busy[3]) begin
      bad++;
      $display("FAIL gate_near_tick got busy0=%b busy3=%b want 0 0", busy[0], busy[3]);
    end
    total++;
    if ({pos_x[0], pos_y[0], pos_x[3], pos_y[3]} !== {10'd100, 10'd100, 10'd100, 10'd100}) begin
      bad++;
      $display("FAIL gate_pos got (%0d,%0d) (%0d,%0d) want (100,100) (100,100)",
               pos_x[0], pos_y[0], pos_x[3], pos_y[3]);
    end
    for (int t = 1; t <= 4; t++) begin
      drive_tick();
      step();
      drive_idle();
      repeat (LAT + 1) step();
      total++;
      if (pos_x[3] !== 10'(100 + 2 * (t / 2))) begin
        bad++;
        $display("FAIL divider tick=%0d got pos_x=%0d want %0d", t, pos_x[3], 100 + 2 * (t / 2));
      end
      total++;
      if (pos_x[0] !== 10'(100 + 2 * t)) begin
        bad++;
        $display("FAIL no_divider tick=%0d got pos_x=%0d want %0d", t, pos_x[0], 100 + 2 * t);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    osq_x = 10'd500; osq_y = 10'd0; enable = 1'b1;
    drive_tick();
    step();          // after E: STEP_X
    drive_idle();
    step();          // after E+1: STEP_Y
    rst_pix = 1'b1;
    step();
    model_init();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== expv(m[i], 1'b0, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_mid inst=%0d got %s want %s", i, fmt(obs(i)), fmt(expv(m[i], 1'b0, 1'b0, 1'b0)));
      end
    end
    rst_pix = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      step();
      total++;
      if (obs(0) !== expv(m[0], 1'b0, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL reset_mid_after cycle=%0d got %s want %s", k, fmt(obs(0)), fmt(expv(m[0], 1'b0, 1'b0, 1'b0)));
      end
    end
  endtask

  task automatic test_random();
    msq_t mo [N];
    bit   upd [N];
    bit   hw [N];
    bit   hs [N];
    apply_reset();
    for (int it = 0; it < 80; it++) begin
      int ox, oy;
      bit en_now, all_start;
      if ($urandom_range(0, 1) == 0) begin
        ox = m[0].x + int'($urandom_range(0, 100)) - 50;
        oy = m[0].y + int'($urandom_range(0, 100)) - 50;
        if (ox < 0) ox = 0;
        if (oy < 0) oy = 0;
      end else begin
        ox = int'($urandom_range(0, H_RES - 1));
        oy = int'($urandom_range(0, V_RES - 1));
      end
      osq_x  = 10'(ox);
      osq_y  = 10'(oy);
      enable = ($urandom_range(0, 3) != 0);
      // Decoy scan positions that are not a frame tick.
      repeat ($urandom_range(1, 3)) begin
        case ($urandom_range(0, 2))
          0: begin sx = 10'd0; sy = 10'(V_RES - 1); end
          1: begin sx = 10'($urandom_range(1, 799)); sy = 10'(V_RES); end
          default: begin sx = 10'($urandom_range(0, 799)); sy = 10'($urandom_range(0, V_RES - 1)); end
        endcase
        step();
        for (int i = 0; i < N; i++) begin
          total++;
          if (obs(i) !== expv(m[i], 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL rand_decoy it=%0d inst=%0d got %s want %s", it, i, fmt(obs(i)), fmt(expv(m[i], 1'b0, 1'b0, 1'b0)));
          end
        end
      end
      en_now    = enable;
      mo        = m;
      all_start = en_now;
      for (int i = 0; i < N; i++) begin
        upd[i] = 1'b0; hw[i] = 1'b0; hs[i] = 1'b0;
        if (en_now) model_tick(i, ox, oy, upd[i], hw[i], hs[i]);
        all_start = all_start & upd[i];
      end
      drive_tick();
      step();
      drive_idle();
      for (int k = 0; k <= LAT + 1; k++) begin
        for (int i = 0; i < N; i++) begin
          logic [24:0] e;
          e = (k < LAT) ? expv(mo[i], upd[i], 1'b0, 1'b0)
                        : expv(m[i], 1'b0, (k == LAT) && hw[i], (k == LAT) && hs[i]);
          total++;
          if (obs(i) !== e) begin
            bad++;
            $display("FAIL rand it=%0d edge=E+%0d inst=%0d got %s want %s", it, k, i, fmt(obs(i)), fmt(e));
          end
        end
        if (k == LAT + 1) break;
        // Enable may drop mid-update; a repeated tick while busy is ignored.
        enable = 1'($urandom_range(0, 1));
        if (k == 0 && all_start && $urandom_range(0, 1) == 1) drive_tick();
        step();
        drive_idle();
      end
    end
  endtask

  initial begin
    rst_pix = 1'b1;
    enable  = 1'b0;
    sx      = 10'd0;
    sy      = 10'd0;
    osq_x   = 10'd0;
    osq_y   = 10'd0;
    test_reset();
    test_single_update();
    test_wall_bounce();
    test_collision();
    test_gating_divider();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
